// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM host interface: controller state codes,
// refresh and mode-register constants, and host address field layout.
package sdram_pkg;

    // Controller FSM state codes as seen on the state input.
    typedef enum logic [4:0] {
        StIdle    = 5'b00000,
        StRefPre  = 5'b00001,
        StWrAct   = 5'b11000,
        StWrCmd   = 5'b11010,
        StRdAct   = 5'b10000,
        StRdCmd   = 5'b10010,
        StRdDone  = 5'b10100,
        StInitMrs = 5'b01110
    } sdram_state_e;

    // Latched host operation; reset value is read.
    typedef enum logic {
        OpRead  = 1'b0,
        OpWrite = 1'b1
    } sdram_op_e;

    localparam int unsigned REFRESH_THRESH = 519;

    // CAS latency 2, burst length 1.
    localparam logic [12:0] MODE_REG    = 13'h020;
    // A10 high selects all banks for precharge.
    localparam logic [12:0] A10_ALLBANK = 13'h0400;

    localparam int unsigned ADDR_W = 24;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned BA_W   = 2;
    localparam int unsigned ROW_W  = 13;
    localparam int unsigned COL_W  = 9;
    localparam int unsigned SA_W   = 13;
    localparam int unsigned CNT_W  = 10;

    // The whole 01xxx range belongs to the power-up initialisation sequence.
    function automatic logic is_init_state(input logic [4:0] s);
        return s[4:3] == 2'b01;
    endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Free-running refresh interval counter. Held at zero during initialisation,
// cleared whenever the controller starts a refresh, saturates at its maximum.
module sdram_refresh_timer
    import sdram_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET,
    input  logic [4:0]       i_state,
    output logic [CNT_W-1:0] o_refresh_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_cnt;
    logic             w_clear;

    assign w_clear = is_init_state(i_state) || (i_state == StRefPre);

    // Count cycles since the last refresh; clear takes priority over increment.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_cnt <= '0;
        end else if (w_clear) begin
            r_cnt <= '0;
        end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_refresh_cnt = r_cnt;

endmodule

// File: rtl/sdram_host_if.sv
// Host-side front end of an SDRAM controller. Accepts one read or write at a
// time, holds it pending until the controller activates the row, drives the
// SDRAM address/data lines from the latched request and returns read data.
module sdram_host_if
    import sdram_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_ready,
    output logic              wr_done,
    input  logic [4:0]        state,
    output logic [CNT_W-1:0]  refresh_cnt,
    output logic              rd_enable,
    output logic              wr_enable,
    input  logic [DATA_W-1:0] dq_in,
    output logic [DATA_W-1:0] dq_out,
    output logic              dq_oe,
    output logic [SA_W-1:0]   sdram_addr,
    output logic [BA_W-1:0]   sdram_ba
);

    logic              r_pending;
    sdram_op_e         r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_ready;
    logic              r_wr_done;

    logic              w_accept;
    logic              w_act_hit;
    logic [ROW_W-1:0]  w_row;
    logic [SA_W-1:0]   w_col;
    logic [SA_W-1:0]   w_sdram_addr;

    sdram_refresh_timer u_refresh_timer (
        .CLK           (CLK),
        .RESET         (RESET),
        .i_state       (state),
        .o_refresh_cnt (refresh_cnt)
    );

    assign busy     = r_pending | (state != StIdle);
    assign w_accept = !busy && (rd_req || wr_req);

    // The activate matching the pending op hands the request to the controller.
    assign w_act_hit = ((state == StRdAct) && (r_op == OpRead)) ||
                       ((state == StWrAct) && (r_op == OpWrite));

    // Request capture: one outstanding request, new requests ignored while busy.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_pending <= 1'b0;
            r_op      <= OpRead;
            r_addr    <= '0;
            r_wr_data <= '0;
        end else if (w_accept) begin
            r_pending <= 1'b1;
            r_op      <= rd_req ? OpRead : OpWrite;
            r_addr    <= addr;
            r_wr_data <= wr_data;
        end else if (w_act_hit) begin
            r_pending <= 1'b0;
        end
    end

    // Completion: capture read data and raise one-cycle done pulses.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_rd_data  <= '0;
            r_rd_ready <= 1'b0;
            r_wr_done  <= 1'b0;
        end else begin
            r_rd_ready <= (state == StRdDone);
            r_wr_done  <= (state == StWrCmd);
            if (state == StRdDone) begin
                r_rd_data <= dq_in;
            end
        end
    end

    assign w_row = r_addr[COL_W +: ROW_W];
    // Column is 9 bits wide, so A10 (auto-precharge) stays low.
    assign w_col = {{(SA_W-COL_W){1'b0}}, r_addr[COL_W-1:0]};

    // SDRAM address mux by controller phase.
    always_comb begin
        w_sdram_addr = A10_ALLBANK;
        case (state)
            StRdAct, StWrAct: w_sdram_addr = w_row;
            StRdCmd, StWrCmd: w_sdram_addr = w_col;
            StInitMrs:        w_sdram_addr = MODE_REG;
            default:          w_sdram_addr = A10_ALLBANK;
        endcase
    end

    assign sdram_addr = w_sdram_addr;
    assign sdram_ba   = r_addr[ADDR_W-1 -: BA_W];
    assign rd_enable  = r_pending && (r_op == OpRead);
    assign wr_enable  = r_pending && (r_op == OpWrite);
    assign dq_out     = r_wr_data;
    assign dq_oe      = (state == StWrCmd);
    assign rd_data    = r_rd_data;
    assign rd_ready   = r_rd_ready;
    assign wr_done    = r_wr_done;

endmodule

// File: tb/tb_sdram_host_if.sv
// Directed bench for sdram_host_if. The bench plays the controller by driving
// state; completions are checked by a scoreboard monitor on the falling edge.
module tb_sdram_host_if;
    import sdram_pkg::*;

    localparam logic [4:0] ST_INIT     = 5'b01000;
    localparam logic [4:0] ST_RD_WAIT  = 5'b10001;
    localparam logic [4:0] ST_WR_WAIT  = 5'b11001;
    localparam logic [4:0] ST_REF_WAIT = 5'b00010;

    logic        CLK;
    logic        RESET;
    logic        rd_req;
    logic        wr_req;
    logic [23:0] addr;
    logic [15:0] wr_data;
    logic        busy;
    logic [15:0] rd_data;
    logic        rd_ready;
    logic        wr_done;
    logic [4:0]  state;
    logic [9:0]  refresh_cnt;
    logic        rd_enable;
    logic        wr_enable;
    logic [15:0] dq_in;
    logic [15:0] dq_out;
    logic        dq_oe;
    logic [12:0] sdram_addr;
    logic [1:0]  sdram_ba;

    typedef struct {
        bit          is_rd;
        logic [15:0] data;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    sdram_host_if dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .rd_req      (rd_req),
        .wr_req      (wr_req),
        .addr        (addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .rd_data     (rd_data),
        .rd_ready    (rd_ready),
        .wr_done     (wr_done),
        .state       (state),
        .refresh_cnt (refresh_cnt),
        .rd_enable   (rd_enable),
        .wr_enable   (wr_enable),
        .dq_in       (dq_in),
        .dq_out      (dq_out),
        .dq_oe       (dq_oe),
        .sdram_addr  (sdram_addr),
        .sdram_ba    (sdram_ba)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input bit is_rd, input logic [15:0] d, input int lat);
        exp_t e;
        e.is_rd = is_rd;
        e.data  = d;
        e.lat   = lat;
        e.acc   = cyc;
        sb.push_back(e);
    endtask

    // Controller read path from IDLE: ACT, wait, READ, two CAS waits, data.
    task automatic rd_path(input logic [15:0] d, input logic [12:0] row,
                           input logic [12:0] col, input logic [1:0] ba);
        state = StRdAct;
        #1;
        chk("rd_act_ba", sdram_ba, ba);
        chk("rd_act_row", sdram_addr, row);
        chk("rd_act_rd_enable", rd_enable, 1);
        step();
        state = ST_RD_WAIT;
        #1;
        chk("rd_wait_rd_enable", rd_enable, 0);
        chk("rd_wait_busy", busy, 1);
        chk("rd_wait_addr", sdram_addr, 13'h0400);
        step();
        state = StRdCmd;
        #1;
        chk("rd_cmd_col", sdram_addr, col);
        chk("rd_cmd_dq_oe", dq_oe, 0);
        step();
        state = ST_RD_WAIT;
        step();
        step();
        state = StRdDone;
        dq_in = d;
        step();
        state = StIdle;
        dq_in = 16'h0000;
    endtask

    // Scoreboard monitor: every completion pulse must match the oldest expectation.
    always @(negedge CLK) begin : monitor
        exp_t e;
        if (rd_ready || wr_done) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_resp: got rd_ready=%0b wr_done=%0b expected none",
                         rd_ready, wr_done);
            end else begin
                e = sb.pop_front();
                chk("resp_is_read", {31'd0, rd_ready}, {31'd0, e.is_rd});
                chk("resp_is_write", {31'd0, wr_done}, {31'd0, !e.is_rd});
                if (e.is_rd) chk("resp_rd_data", rd_data, e.data);
                chk("resp_latency", cyc - e.acc, e.lat);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stim
        RESET   = 1'b0;
        state   = ST_INIT;
        rd_req  = 1'b0;
        wr_req  = 1'b0;
        addr    = 24'h0;
        wr_data = 16'h0;
        dq_in   = 16'h0;
        repeat (3) step();
        #1;
        chk("rst_refresh_cnt", refresh_cnt, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_dq_out", dq_out, 0);
        chk("rst_rd_enable", rd_enable, 0);
        RESET = 1'b1;

        // Initialisation: counter held at zero, host sees busy.
        for (int i = 0; i < 20; i++) begin
            step();
            state = (i == 19) ? StInitMrs : ST_INIT;
        end
        #1;
        chk("init_refresh_cnt", refresh_cnt, 0);
        chk("init_busy", busy, 1);
        chk("init_rd_ready", rd_ready, 0);
        chk("init_wr_done", wr_done, 0);
        chk("init_mrs_addr", sdram_addr, 13'h020);
        step();
        state = StIdle;
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_addr", sdram_addr, 13'h0400);
        chk("idle_refresh_cnt", refresh_cnt, 0);
        repeat (5) step();
        #1;
        chk("count_5", refresh_cnt, 5);

        // Read C0_0205: bank 3, row 1, column 5.
        addr   = 24'hC0_0205;
        rd_req = 1'b1;
        step();
        push(1'b1, 16'hBEEF, 7);
        rd_req = 1'b0;
        #1;
        chk("rd1_rd_enable", rd_enable, 1);
        chk("rd1_wr_enable", wr_enable, 0);
        chk("rd1_busy", busy, 1);
        step();
        rd_path(16'hBEEF, 13'h0001, 13'h0005, 2'd3);

        // Write 41_2A33: bank 1, row 0x095, column 0x033.
        addr    = 24'h41_2A33;
        wr_data = 16'h1234;
        wr_req  = 1'b1;
        step();
        push(1'b0, 16'h0000, 4);
        wr_req = 1'b0;
        #1;
        chk("wr_wr_enable", wr_enable, 1);
        chk("wr_rd_enable", rd_enable, 0);
        chk("wr_dq_out", dq_out, 16'h1234);
        chk("wr_dq_oe_idle", dq_oe, 0);
        step();
        state = StWrAct;
        #1;
        chk("wr_act_row", sdram_addr, 13'h095);
        chk("wr_act_ba", sdram_ba, 1);
        step();
        state = ST_WR_WAIT;
        #1;
        chk("wr_wait_wr_enable", wr_enable, 0);
        chk("wr_wait_dq_oe", dq_oe, 0);
        step();
        state = StWrCmd;
        #1;
        chk("wr_cmd_dq_oe", dq_oe, 1);
        chk("wr_cmd_dq_out", dq_out, 16'h1234);
        chk("wr_cmd_col", sdram_addr, 13'h033);
        step();
        state = StIdle;
        #1;
        chk("wr_after_dq_oe", dq_oe, 0);
        chk("rd_data_held", rd_data, 16'hBEEF);

        // Simultaneous requests: read wins; request made while busy is dropped.
        addr    = 24'h80_0C0A;
        wr_data = 16'hAAAA;
        rd_req  = 1'b1;
        wr_req  = 1'b1;
        step();
        push(1'b1, 16'hCAFE, 7);
        rd_req  = 1'b0;
        addr    = 24'h00_0000;
        wr_data = 16'h5555;
        #1;
        chk("both_rd_enable", rd_enable, 1);
        chk("both_wr_enable", wr_enable, 0);
        step();
        wr_req = 1'b0;
        #1;
        chk("ignored_dq_out", dq_out, 16'hAAAA);
        chk("ignored_wr_enable", wr_enable, 0);
        rd_path(16'hCAFE, 13'h0006, 13'h000A, 2'd2);

        // Refresh while a read is pending.
        state = StRefPre;
        step();
        state = StIdle;
        repeat (599) step();
        addr   = 24'h3F_FFFF;
        rd_req = 1'b1;
        step();
        push(1'b1, 16'h0F0F, 10);
        rd_req = 1'b0;
        state  = StRefPre;
        #1;
        chk("ref_cnt_600", refresh_cnt, 600);
        chk("ref_rd_enable_pre", rd_enable, 1);
        step();
        state = ST_REF_WAIT;
        #1;
        chk("ref_cnt_clear", refresh_cnt, 0);
        chk("ref_rd_enable_held", rd_enable, 1);
        chk("ref_busy", busy, 1);
        step();
        step();
        state = StIdle;
        #1;
        chk("ref_cnt_2", refresh_cnt, 2);
        chk("ref_rd_enable_after", rd_enable, 1);
        step();
        rd_path(16'h0F0F, 13'h1FFF, 13'h01FF, 2'd0);

        // Counter saturation.
        repeat (1100) step();
        #1;
        chk("cnt_saturate", refresh_cnt, 1023);

        // Reset while a write is still pending drops it.
        addr    = 24'h00_0010;
        wr_data = 16'h7777;
        wr_req  = 1'b1;
        step();
        wr_req = 1'b0;
        RESET  = 1'b0;
        step();
        #1;
        chk("rst_pend_wr_enable", wr_enable, 0);
        chk("rst_pend_busy", busy, 0);
        chk("rst_pend_dq_out", dq_out, 0);
        RESET = 1'b1;
        step();

        // Reset asserted during RD_CMD: no completion, read data cleared.
        addr   = 24'h00_0201;
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        step();
        state = StRdAct;
        step();
        state = ST_RD_WAIT;
        step();
        state = StRdCmd;
        RESET = 1'b0;
        step();
        state = ST_RD_WAIT;
        #1;
        chk("rst_rd_enable", rd_enable, 0);
        chk("rst_busy_held", busy, 1);
        chk("rst_rd_data_clr", rd_data, 0);
        step();
        state = StRdDone;
        dq_in = 16'hDEAD;
        step();
        state = StIdle;
        dq_in = 16'h0000;
        #1;
        chk("rst_idle_busy", busy, 0);
        chk("rst_no_capture", rd_data, 0);
        step();
        RESET = 1'b1;
        repeat (3) step();
        #1;
        chk("post_rst_rd_data", rd_data, 0);
        chk("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_host_if.md
SDRAM_HOST_IF -- requirements
Module: sdram_host_if

Interface
REQ-001 SHALL have ports: CLK input 1 clock; RESET input 1 reset (synchronous, active-low); clock CLK.
REQ-002 SHALL have ports: rd_req input 1 host read request; wr_req input 1 host write request; addr input 24 host word address; wr_data input 16 host write word.
REQ-003 SHALL have ports: busy output 1 request not accepted; rd_data output 16 read word; rd_ready output 1 rd_data valid pulse; wr_done output 1 write-issued pulse.
REQ-004 SHALL have ports: state input 5 controller FSM state; refresh_cnt output 10; rd_enable output 1; wr_enable output 1.
REQ-005 SHALL have ports: dq_in input 16; dq_out output 16; dq_oe output 1; sdram_addr output 13; sdram_ba output 2.

Function
REQ-006 State codes SHALL be: IDLE 00000, REF_PRE 00001, WR_ACT 11000, WR_CMD 11010, RD_ACT 10000, RD_CMD 10010, RD_DONE 10100, INIT_MRS 01110, INIT group 01xxx.
REQ-007 refresh_cnt SHALL increment by 1 each cycle, saturating at 1023, while state is not in the INIT group.
REQ-008 refresh_cnt SHALL hold 0 while state is in the INIT group and SHALL load 0 on any cycle with state == REF_PRE (clear wins over increment).
REQ-009 busy SHALL equal pending OR (state != IDLE); combinational.
REQ-010 A request SHALL be accepted on a rising edge with busy == 0 and (rd_req or wr_req) high; rd_req wins if both high.
REQ-011 On accept: addr, wr_data and op latched; pending set; requests with busy == 1 SHALL be ignored, not queued.
REQ-012 rd_enable SHALL equal pending AND op==read; wr_enable SHALL equal pending AND op==write.
REQ-013 pending SHALL clear on the edge where state == RD_ACT (read) or WR_ACT (write); pending held while state in refresh sequence.
REQ-014 Address split: sdram_ba = addr_l[23:22], row = addr_l[21:9], col = {4'b0, addr_l[8:0]}.
REQ-015 sdram_addr SHALL be row in RD_ACT/WR_ACT, {col with bit10 = 0} in RD_CMD/WR_CMD, MODE_REG (13'h020, CAS 2, burst 1) in INIT_MRS, 13'h0400 (A10 all-bank) otherwise.
REQ-016 dq_out SHALL equal latched wr_data; dq_oe SHALL be 1 exactly when state == WR_CMD.
REQ-017 On the edge where state == RD_DONE, rd_data SHALL load dq_in and rd_ready SHALL be 1 for the following cycle only.
REQ-018 On the edge where state == WR_CMD, wr_done SHALL be 1 for the following cycle only.
REQ-019 rd_data SHALL hold its value until the next read completes.
REQ-020 Latency: accept to rd_ready high = 7 cycles with no refresh intervening; refresh in IDLE delays by its duration.

Reset
REQ-021 RESET low on an edge SHALL clear pending, op, refresh_cnt, rd_data, rd_ready, wr_done, latched addr and wr_data to 0.
REQ-022 Reset mid-transaction SHALL drop the request without rd_ready/wr_done; busy stays high until state returns to IDLE.

Structure
REQ-023 Package sdram_pkg SHALL hold state codes, REFRESH_THRESH = 519, MODE_REG, address field widths.
REQ-024 Sub-module sdram_refresh_timer SHALL implement REQ-007/008.
REQ-025 All storage SHALL be single-clock CLK flops; no latches.

Verification
REQ-026 Reset then state held in INIT group 20 cycles -> refresh_cnt 0, busy 1, rd_ready 0, wr_done 0.
REQ-027 State IDLE, rd_req, addr 24'hC0_0205 -> rd_enable next cycle; RD_ACT: sdram_ba 3, sdram_addr 13'h0001; RD_CMD: 13'h0005; dq_in 16'hBEEF at RD_DONE -> rd_data BEEF, rd_ready 1 cycle.
REQ-028 wr_req, wr_data 16'h1234 -> at WR_CMD dq_oe 1, dq_out 1234; wr_done pulse next cycle; dq_oe 0 otherwise.
REQ-029 rd_req and wr_req same cycle in IDLE -> read only; second request while busy ignored.
REQ-030 refresh_cnt 600, state to REF_PRE while read pending -> refresh_cnt 0 next cycle, rd_enable held, read completes after refresh.
REQ-031 Reset asserted during RD_CMD -> no rd_ready, rd_data 0, pending 0.
